rmii_tx_framer: RTL and testbench

- Transmit-side framer driving the RMII TX pins (tx0, tx1, tx_en) that the hack_if monitor captures.
- Takes payload bytes on a valid/ready/last byte stream.
- Prepends the preamble and SFD, serialises each byte as 2-bit dibits LSB-first at one dibit per clk_50 cycle, optionally appends the Ethernet FCS, then enforces the inter-frame gap.

---
 rtl/rmii_tx_framer.sv | 206 ++++++++++++++++++++
 tb/tb_rmii_tx_framer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_tx_framer.sv
// RMII transmit framer: preamble/SFD, LSB-first dibit serialisation of a byte
// stream, optional CRC-32 FCS, and inter-frame gap enforcement.
module rmii_tx_framer #(
    parameter int PREAMBLE_BYTES = 7,
    parameter bit ADD_FCS        = 1'b1,
    parameter int IFG_CYCLES     = 48
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       tx0,
    output logic       tx1,
    output logic       tx_en,
    output logic       busy,
    output logic       frame_done,
    output logic       err_underrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_FCS,
        ST_IFG,
        ST_DRAIN
    } state_t;

    localparam logic [5:0]  SFD_LAST = 6'((PREAMBLE_BYTES + 1) * 4 - 1);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [7:0]  ifg_cnt_q, ifg_cnt_d;
    logic [31:0] shift_q, shift_d;
    logic        last_q, last_d;
    logic [31:0] crc_q, crc_d;
    logic        tx_en_q, tx_en_d;
    logic [1:0]  dibit_q, dibit_d;
    logic        frame_done_q, frame_done_d;
    logic        underrun_q, underrun_d;
    logic        fetch_slot;

    // Reflected CRC-32, one payload byte per call.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // A byte is fetched while the final dibit of the SFD or of a non-last byte is on the wire.
    assign fetch_slot = ((state_q == ST_PREAMBLE) && (cnt_q == SFD_LAST)) ||
                        ((state_q == ST_DATA) && (cnt_q == 6'd3) && !last_q);

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ifg_cnt_q    <= '0;
            shift_q      <= '0;
            last_q       <= 1'b0;
            crc_q        <= '1;
            tx_en_q      <= 1'b0;
            dibit_q      <= 2'b00;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ifg_cnt_q    <= ifg_cnt_d;
            shift_q      <= shift_d;
            last_q       <= last_d;
            crc_q        <= crc_d;
            tx_en_q      <= tx_en_d;
            dibit_q      <= dibit_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ifg_cnt_d = ifg_cnt_q;
        shift_d   = shift_q;
        last_d    = last_q;
        crc_d     = crc_q;
        case (state_q)
            ST_IDLE: begin
                crc_d = '1;
                cnt_d = '0;
                if (s_valid) begin
                    state_d = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (cnt_q == SFD_LAST) begin
                    if (s_valid) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        shift_d = {24'h0, s_data};
                        last_d  = s_last;
                        crc_d   = crc32_byte(crc_q, s_data);
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == 6'd3) begin
                    cnt_d = '0;
                    if (last_q) begin
                        if (ADD_FCS) begin
                            state_d = ST_FCS;
                            shift_d = ~crc_q;
                        end else begin
                            state_d   = ST_IFG;
                            ifg_cnt_d = '0;
                        end
                    end else if (s_valid) begin
                        shift_d = {24'h0, s_data};
                        last_d  = s_last;
                        crc_d   = crc32_byte(crc_q, s_data);
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    cnt_d   = cnt_q + 6'd1;
                    shift_d = shift_q >> 2;
                end
            end
            ST_FCS: begin
                if (cnt_q == 6'd15) begin
                    state_d   = ST_IFG;
                    ifg_cnt_d = '0;
                end else begin
                    cnt_d   = cnt_q + 6'd1;
                    shift_d = shift_q >> 2;
                end
            end
            ST_IFG: begin
                crc_d = '1;
                if (ifg_cnt_q == IFG_LAST) begin
                    cnt_d = '0;
                    // A waiting frame skips IDLE so the gap is exactly IFG_CYCLES.
                    state_d = s_valid ? ST_PREAMBLE : ST_IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (s_valid && s_last) begin
                    state_d   = ST_IFG;
                    ifg_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_en_d      = 1'b0;
        dibit_d      = 2'b00;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        s_ready      = fetch_slot || (state_q == ST_DRAIN);
        busy         = (state_q != ST_IDLE);
        case (state_d)
            ST_PREAMBLE: begin
                tx_en_d = 1'b1;
                dibit_d = (cnt_d == SFD_LAST) ? 2'b11 : 2'b01;
            end
            ST_DATA, ST_FCS: begin
                tx_en_d = 1'b1;
                dibit_d = shift_d[1:0];
            end
            default: begin
                tx_en_d = 1'b0;
                dibit_d = 2'b00;
            end
        endcase
        if (((state_q == ST_DATA) || (state_q == ST_FCS)) && (state_d == ST_IFG)) begin
            frame_done_d = 1'b1;
        end
        if (((state_q == ST_PREAMBLE) || (state_q == ST_DATA)) && (state_d == ST_DRAIN)) begin
            underrun_d = 1'b1;
        end
    end

    assign tx0          = dibit_q[0];
    assign tx1          = dibit_q[1];
    assign tx_en        = tx_en_q;
    assign frame_done   = frame_done_q;
    assign err_underrun = underrun_q;

endmodule

// File: tb/tb_rmii_tx_framer.sv
// Directed bench for rmii_tx_framer: three parameterisations, a negedge wire
// monitor that records dibits, run lengths and pulses, and hand-computed frames.
module tb_rmii_tx_framer;

    localparam int WAIT_LIMIT = 3000;

    logic       clk;
    logic       rst_n;
    logic [7:0] s_data [3];
    logic [2:0] s_valid;
    logic [2:0] s_last;
    logic [2:0] rdy_w, en_w, tx0_w, tx1_w, busy_w, done_w, err_w;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] pay  [0:15];
    logic [7:0] expb [0:15];

    logic [1:0] dib  [3][256];
    logic [1:0] snap [3][256];
    bit   [2:0] en_prev = '0;
    int dn[3], run[3], low_run[3], len_last[3], gap_last[3];
    int frames_seen[3], done_cnt[3], err_cnt[3], idle_bad[3], fall_done[3];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    rmii_tx_framer #(.PREAMBLE_BYTES(7), .ADD_FCS(1'b1), .IFG_CYCLES(48)) u_dut_fcs (
        .clk_50(clk), .rst_n(rst_n), .s_data(s_data[0]), .s_valid(s_valid[0]),
        .s_last(s_last[0]), .s_ready(rdy_w[0]), .tx0(tx0_w[0]), .tx1(tx1_w[0]),
        .tx_en(en_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]), .err_underrun(err_w[0]));

    rmii_tx_framer #(.PREAMBLE_BYTES(7), .ADD_FCS(1'b0), .IFG_CYCLES(48)) u_dut_nofcs (
        .clk_50(clk), .rst_n(rst_n), .s_data(s_data[1]), .s_valid(s_valid[1]),
        .s_last(s_last[1]), .s_ready(rdy_w[1]), .tx0(tx0_w[1]), .tx1(tx1_w[1]),
        .tx_en(en_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]), .err_underrun(err_w[1]));

    rmii_tx_framer #(.PREAMBLE_BYTES(1), .ADD_FCS(1'b1), .IFG_CYCLES(1)) u_dut_min (
        .clk_50(clk), .rst_n(rst_n), .s_data(s_data[2]), .s_valid(s_valid[2]),
        .s_last(s_last[2]), .s_ready(rdy_w[2]), .tx0(tx0_w[2]), .tx1(tx1_w[2]),
        .tx_en(en_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]), .err_underrun(err_w[2]));

    // Wire monitor: records each tx_en-high run and the low gap before it.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (en_w[k]) begin
                if (!en_prev[k]) begin
                    dib[k][0]   <= {tx1_w[k], tx0_w[k]};
                    dn[k]       <= 1;
                    run[k]      <= 1;
                    gap_last[k] <= low_run[k];
                end else begin
                    if (dn[k] < 256) dib[k][dn[k]] <= {tx1_w[k], tx0_w[k]};
                    dn[k]  <= dn[k] + 1;
                    run[k] <= run[k] + 1;
                end
                low_run[k] <= 0;
            end else begin
                if (en_prev[k]) begin
                    len_last[k] <= run[k];
                    for (int i = 0; i < 256; i++) snap[k][i] <= dib[k][i];
                    frames_seen[k] <= frames_seen[k] + 1;
                    if (done_w[k]) fall_done[k] <= fall_done[k] + 1;
                    low_run[k] <= 1;
                end else begin
                    low_run[k] <= low_run[k] + 1;
                end
                if (tx0_w[k] || tx1_w[k]) idle_bad[k] <= idle_bad[k] + 1;
            end
            if (done_w[k]) done_cnt[k] <= done_cnt[k] + 1;
            if (err_w[k])  err_cnt[k]  <= err_cnt[k] + 1;
            en_prev[k] <= en_w[k];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int k, input string tag);
        int t;
        t = 0;
        while (!rdy_w[k] && t < WAIT_LIMIT) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, " s_ready timeout"}, 32'(int'(t >= WAIT_LIMIT)), 32'd0);
    endtask

    task automatic wait_frames(input int k, input int target, input string tag);
        int t;
        t = 0;
        while (frames_seen[k] < target && t < WAIT_LIMIT) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, " frame end timeout"}, 32'(int'(t >= WAIT_LIMIT)), 32'd0);
    endtask

    // Drives pay[0..n-1]; at byte drop_at one fetch slot is left empty first.
    task automatic send_frame(input int k, input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) begin
                s_valid[k] = 1'b0;
                wait_ready(k, "drop slot");
                @(negedge clk);
            end
            s_data[k]  = pay[i];
            s_last[k]  = (i == n - 1);
            s_valid[k] = 1'b1;
            wait_ready(k, "fetch");
            @(negedge clk);
        end
        s_valid[k] = 1'b0;
        s_last[k]  = 1'b0;
    endtask

    task automatic set_exp(input int n, input logic [31:0] fcs, input bit with_fcs);
        for (int i = 0; i < n; i++) expb[i] = pay[i];
        if (with_fcs) begin
            expb[n]     = fcs[7:0];
            expb[n + 1] = fcs[15:8];
            expb[n + 2] = fcs[23:16];
            expb[n + 3] = fcs[31:24];
        end
    endtask

    task automatic check_frame(input int k, input string tag, input int pb, input int nb);
        int base;
        int bad;
        logic [7:0] got;
        base = (pb + 1) * 4;
        bad  = 0;
        check_eq({tag, " tx_en length"}, len_last[k], base + 4 * nb);
        for (int i = 0; i < base - 1; i++) if (snap[k][i] !== 2'b01) bad++;
        if (snap[k][base - 1] !== 2'b11) bad++;
        check_eq({tag, " preamble/SFD bad dibits"}, bad, 0);
        for (int j = 0; j < nb; j++) begin
            got = {snap[k][base + 4*j + 3], snap[k][base + 4*j + 2],
                   snap[k][base + 4*j + 1], snap[k][base + 4*j]};
            check_eq($sformatf("%s byte%0d", tag, j), got, expb[j]);
        end
        $display("frame %s: dut %0d, tx_en high %0d cycles, %0d bytes after SFD", tag, k, len_last[k], nb);
    endtask

    initial begin
        int base;
        rst_n   = 1'b0;
        s_valid = '0;
        s_last  = '0;
        for (int k = 0; k < 3; k++) s_data[k] = 8'h00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("reset outputs dut%0d", k),
                     32'({rdy_w[k], en_w[k], tx1_w[k], tx0_w[k], busy_w[k], done_w[k], err_w[k]}), 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte, no FCS: 28x01, SFD, then 01,01,10,10.
        pay[0] = 8'hA5;
        set_exp(1, 32'h0, 1'b0);
        base = frames_seen[1];
        send_frame(1, 1, -1);
        wait_frames(1, base + 1, "t1");
        check_frame(1, "t1", 7, 1);

        // "123456789" with FCS 0xCBF43926.
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        set_exp(9, 32'hCBF43926, 1'b1);
        base = frames_seen[0];
        send_frame(0, 9, -1);
        wait_frames(0, base + 1, "t2");
        check_frame(0, "t2", 7, 13);

        // Back-to-back single 0x00 frames with s_valid held high.
        pay[0] = 8'h00;
        set_exp(1, 32'hD202EF8D, 1'b1);
        base = frames_seen[0];
        send_frame(0, 1, -1);
        send_frame(0, 1, -1);
        check_frame(0, "t3a", 7, 5);
        wait_frames(0, base + 2, "t3b");
        check_frame(0, "t3b", 7, 5);
        check_eq("t3 inter-frame gap", gap_last[0], 48);

        // Underrun at the third fetch, drain through s_last, then a good frame.
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44; pay[4] = 8'h55;
        set_exp(2, 32'h0, 1'b0);
        base = frames_seen[0];
        send_frame(0, 5, 2);
        wait_frames(0, base + 1, "t4");
        check_frame(0, "t4 aborted", 7, 2);
        check_eq("t4 err_underrun count", err_cnt[0], 1);
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        set_exp(9, 32'hCBF43926, 1'b1);
        send_frame(0, 9, -1);
        wait_frames(0, base + 2, "t4b");
        check_frame(0, "t4b", 7, 13);
        check_eq("t4 gap (3 drain + 48 ifg)", gap_last[0], 51);

        // Asynchronous reset while the first data dibit is on the wire.
        s_data[0]  = 8'h31;
        s_last[0]  = 1'b0;
        s_valid[0] = 1'b1;
        wait_ready(0, "t5");
        @(negedge clk);
        check_eq("t5 before reset {tx_en,tx1,tx0,busy}", 32'({en_w[0], tx1_w[0], tx0_w[0], busy_w[0]}), 32'b1011);
        #3;
        rst_n      = 1'b0;
        s_valid[0] = 1'b0;
        #1;
        check_eq("t5 async reset {tx_en,tx1,tx0,busy,s_ready}",
                 32'({en_w[0], tx1_w[0], tx0_w[0], busy_w[0], rdy_w[0]}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pay[0] = 8'h00;
        set_exp(1, 32'hD202EF8D, 1'b1);
        base = frames_seen[0];
        send_frame(0, 1, -1);
        wait_frames(0, base + 1, "t5");
        check_frame(0, "t5 after reset", 7, 5);

        // Minimum preamble and one-cycle gap, back to back.
        pay[0] = 8'h00;
        set_exp(1, 32'hD202EF8D, 1'b1);
        base = frames_seen[2];
        send_frame(2, 1, -1);
        send_frame(2, 1, -1);
        check_frame(2, "t6a", 1, 5);
        wait_frames(2, base + 2, "t6b");
        check_frame(2, "t6b", 1, 5);
        check_eq("t6 inter-frame gap", gap_last[2], 1);

        repeat (4) @(negedge clk);
        check_eq("dut0 frame_done count", done_cnt[0], 5);
        check_eq("dut0 frame_done on tx_en fall", fall_done[0], 5);
        check_eq("dut0 err_underrun total", err_cnt[0], 1);
        check_eq("dut1 frame_done count", done_cnt[1], 1);
        check_eq("dut2 frame_done count", done_cnt[2], 2);
        check_eq("dut2 err_underrun total", err_cnt[2], 0);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("dut%0d data while tx_en low", k), idle_bad[k], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
